// File: rtl/sensor_stream_tx.sv
// Framed serial transmitter: buffers parallel samples in a small FIFO and
// shifts each out as start, data MSB-first, optional even parity, stop.
module sensor_stream_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          sensor_data,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop, last_cyc, line;
  state_t            state;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par;

  assign in_ready = reset && (fifo_count != (AW+1)'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign last_cyc = (cyc_cnt == CYC_W'(BIT_CYCLES - 1));
  // Pop from IDLE, or straight out of the last stop cycle for zero-gap frames.
  assign pop      = (fifo_count != '0) &&
                    ((state == IDLE) || ((state == STOP) && last_cyc));

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    line = 1'b0;
    case (state)
      START:   line = 1'b1;
      DATA:    line = shreg[DATA_W-1];
      PARITY:  line = par;
      default: line = 1'b0;
    endcase
  end

  // Outputs are registered images of the current state, so the line lags
  // the FSM by one cycle and never sees in_valid/in_data combinationally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      sensor_data <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sensor_data <= line;
      frame_done  <= (state == STOP) && last_cyc;
      busy        <= (state != IDLE) || (fifo_count != '0);
      case (state)
        IDLE: begin
          cyc_cnt <= '0;
          if (pop) begin
            shreg <= mem[rd_ptr];
            par   <= ^mem[rd_ptr];
            state <= START;
          end
        end
        START: begin
          if (last_cyc) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
            state   <= DATA;
          end else cyc_cnt <= cyc_cnt + CYC_W'(1);
        end
        DATA: begin
          if (last_cyc) begin
            cyc_cnt <= '0;
            shreg   <= {shreg[DATA_W-2:0], 1'b0};
            if (bit_cnt == BIT_W'(DATA_W - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else bit_cnt <= bit_cnt + BIT_W'(1);
          end else cyc_cnt <= cyc_cnt + CYC_W'(1);
        end
        PARITY: begin
          if (last_cyc) begin
            cyc_cnt <= '0;
            state   <= STOP;
          end else cyc_cnt <= cyc_cnt + CYC_W'(1);
        end
        STOP: begin
          if (last_cyc) begin
            cyc_cnt <= '0;
            if (pop) begin
              shreg <= mem[rd_ptr];
              par   <= ^mem[rd_ptr];
              state <= START;
            end else state <= IDLE;
          end else cyc_cnt <= cyc_cnt + CYC_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sensor_stream_tx.sv
// Bench for sensor_stream_tx: two instances (BIT_CYCLES 1 and 3) checked
// every cycle against a frame-schedule model, plus fixed vectors and corners.
module tb_sensor_stream_tx;
  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1;
  logic [7:0] d0, d1;
  logic       r0, r1, s0, s1, b0, b1, f0, f1;
  logic [2:0] c0, c1;
  int         total = 0, bad = 0, cyc = 0;

  always #5 clk = ~clk;

  sensor_stream_tx #(.DATA_W(8), .BIT_CYCLES(1), .FIFO_DEPTH(4), .PARITY_EN(1)) u0 (
    .clk(clk), .reset(rst), .in_data(d0), .in_valid(v0), .in_ready(r0),
    .sensor_data(s0), .busy(b0), .frame_done(f0), .fifo_count(c0));
  sensor_stream_tx #(.DATA_W(8), .BIT_CYCLES(3), .FIFO_DEPTH(4), .PARITY_EN(1)) u1 (
    .clk(clk), .reset(rst), .in_data(d1), .in_valid(v1), .in_ready(r1),
    .sensor_data(s1), .busy(b1), .frame_done(f1), .fifo_count(c1));

  // Model: each accepted sample becomes a frame with a push edge and a pop
  // edge; pop = max(push+1, previous pop + frame length).
  typedef struct { int inst; int push_t; int pop_t; logic [7:0] d; } fr_t;
  fr_t fq[$];
  int  lastpop[2];

  function automatic int bcyc(int i); return (i == 0) ? 1 : 3; endfunction
  function automatic int flen(int i); return 11 * bcyc(i); endfunction

  function automatic int cnt_at(int i, int x);
    int n = 0;
    foreach (fq[j]) if (fq[j].inst == i) begin
      if (fq[j].push_t <= x) n++;
      if (fq[j].pop_t <= x) n--;
    end
    return n;
  endfunction

  function automatic logic fbit(logic [7:0] d, int k);
    if (k == 0) return 1'b1;
    if (k <= 8) return d[8-k];
    if (k == 9) return ^d;
    return 1'b0;
  endfunction

  task automatic chk(string nm, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic model_edge(int i, logic v, logic [7:0] d);
    fr_t keep[$];
    int  p;
    if (!rst) begin
      foreach (fq[j]) if (fq[j].inst != i) keep.push_back(fq[j]);
      fq = keep;
      lastpop[i] = -1000;
    end else if (v && cnt_at(i, cyc - 1) != 4) begin
      p = (cyc + 1 > lastpop[i] + flen(i)) ? cyc + 1 : lastpop[i] + flen(i);
      fq.push_back('{i, cyc, p, d});
      lastpop[i] = p;
    end
  endtask

  task automatic cmp_inst(int i, logic rdy, logic sd, logic fd, logic bz, logic [2:0] cn);
    logic esd = 1'b0, efd = 1'b0, act = 1'b0;
    int   n;
    foreach (fq[j]) if (fq[j].inst == i) begin
      if (cyc >= fq[j].pop_t + 1 && cyc <= fq[j].pop_t + flen(i))
        esd = fbit(fq[j].d, (cyc - fq[j].pop_t - 1) / bcyc(i));
      if (cyc == fq[j].pop_t + flen(i)) efd = 1'b1;
      if (cyc - 1 >= fq[j].pop_t && cyc - 1 < fq[j].pop_t + flen(i)) act = 1'b1;
    end
    n = cnt_at(i, cyc);
    chk($sformatf("u%0d.sensor_data", i), sd, esd);
    chk($sformatf("u%0d.frame_done", i), fd, efd);
    chk($sformatf("u%0d.busy", i), bz, act || (cnt_at(i, cyc - 1) > 0));
    chk($sformatf("u%0d.fifo_count", i), cn, n);
    chk($sformatf("u%0d.in_ready", i), rdy, rst && (n != 4));
  endtask

  task automatic tick();
    fr_t keep[$];
    @(posedge clk);
    cyc++;
    model_edge(0, v0, d0);
    model_edge(1, v1, d1);
    #1;
    cmp_inst(0, r0, s0, f0, b0, c0);
    cmp_inst(1, r1, s1, f1, b1, c1);
    foreach (fq[j]) if (fq[j].pop_t + flen(fq[j].inst) + 2 >= cyc) keep.push_back(fq[j]);
    fq = keep;
  endtask

  task automatic wait_idle(int i);
    int k = 0;
    while (((i == 0) ? (b0 || c0 != 0) : (b1 || c1 != 0)) && k < 200) begin
      tick();
      k++;
    end
    chk($sformatf("u%0d.idle_timeout", i), k < 200, 1);
  endtask

  typedef struct { logic vld; logic [7:0] d; logic sd, fd, bz; logic [2:0] cn; } vec_t;
  vec_t tbl[14];
  int   sdv[14] = '{0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0};

  initial begin
    logic [10:0] exp01;
    int t1, t2, np, nf, ns, p0, pr;
    for (int j = 0; j < 14; j++)
      tbl[j] = '{(j == 0), (j == 0) ? 8'hA5 : 8'h00, sdv[j][0], (j == 12),
                 (j >= 1 && j <= 12), (j == 0) ? 3'd1 : 3'd0};
    lastpop[0] = -1000;
    lastpop[1] = -1000;
    rst = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 8'h3C; d1 = 8'hC3;

    // Reset held with in_valid high: nothing accepted, outputs quiet.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_in_ready", r0, 0);
      chk("rst_sensor_data", s0, 0);
      chk("rst_fifo_count", c0, 0);
      chk("rst_fifo_count1", c1, 0);
    end
    v0 = 1'b0; v1 = 1'b0; rst = 1'b1;
    #1;
    chk("rel_in_ready", r0, 1);
    chk("rel_in_ready1", r1, 1);
    tick(); tick();

    // Single 0xA5 frame, fixed vectors.
    for (int j = 0; j < 14; j++) begin
      v0 = tbl[j].vld; d0 = tbl[j].d;
      tick();
      chk($sformatf("tbl%0d_sd", j), s0, tbl[j].sd);
      chk($sformatf("tbl%0d_fd", j), f0, tbl[j].fd);
      chk($sformatf("tbl%0d_busy", j), b0, tbl[j].bz);
      chk($sformatf("tbl%0d_cnt", j), c0, tbl[j].cn);
    end
    v0 = 1'b0;

    // Odd-weight sample: parity bit is 1.
    wait_idle(0);
    exp01 = 11'b10000000110;
    v0 = 1'b1; d0 = 8'h01;
    tick();
    v0 = 1'b0;
    tick();
    for (int k = 0; k < 11; k++) begin
      tick();
      chk($sformatf("par01_bit%0d", k), s0, exp01[10-k]);
    end

    // Back-to-back frames at 3 cycles/bit: no idle gap, 33 cycles apart.
    wait_idle(1);
    v1 = 1'b1; d1 = 8'h80;
    tick();
    d1 = 8'hFF;
    tick();
    v1 = 1'b0;
    t1 = -1; t2 = -1;
    for (int k = 0; k < 120 && t2 < 0; k++) begin
      tick();
      if (t1 >= 0 && cyc == t1 + 1) chk("b2b_nogap", s1, 1);
      if (f1) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end
    end
    chk("b2b_second_fd", t2 >= 0, 1);
    chk("b2b_spacing", t2 - t1, 33);

    // FIFO full while busy, then pop, then push+pop at count 3.
    wait_idle(1);
    v1 = 1'b1; d1 = 8'h80;
    tick();
    v1 = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      v1 = 1'b1; d1 = 8'(8'h10 + k);
      tick();
    end
    chk("full_cnt", c1, 4);
    chk("full_rdy", r1, 0);
    d1 = 8'h55;
    tick();
    chk("full_ignored_cnt", c1, 4);
    for (int k = 0; k < 60 && !r1; k++) tick();
    v1 = 1'b0;
    chk("full_pop_cnt", c1, 3);
    chk("full_pop_rdy", r1, 1);
    np = cyc + 1;
    foreach (fq[j]) if (fq[j].inst == 1 && fq[j].pop_t > cyc) begin
      np = fq[j].pop_t;
      break;
    end
    for (int k = 0; k < 60 && cyc < np - 1; k++) tick();
    v1 = 1'b1; d1 = 8'h3C;
    tick();
    v1 = 1'b0;
    chk("pushpop_cnt", c1, 3);

    // Reset during the 4th data bit with two samples queued.
    wait_idle(0);
    wait_idle(1);
    p0 = cyc;
    v0 = 1'b1; d0 = 8'hA5;
    tick();
    d0 = 8'h5A;
    tick();
    d0 = 8'hC3;
    tick();
    v0 = 1'b0;
    while (cyc < p0 + 6) tick();
    rst = 1'b0;
    tick();
    chk("midrst_sd", s0, 0);
    chk("midrst_cnt", c0, 0);
    chk("midrst_fd", f0, 0);
    rst = 1'b1;
    nf = 0; ns = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      nf += int'(f0);
      ns += int'(s0);
    end
    chk("midrst_no_fd", nf, 0);
    chk("midrst_no_sd", ns, 0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      pr = 8 + 30 * ((k / 500) % 3);
      rst = ($urandom_range(0, 499) != 0);
      v0 = ($urandom_range(0, 99) < pr);
      v1 = ($urandom_range(0, 99) < pr);
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
